// File: rtl/ahb_lite_master_cmd.sv
// AHB-Lite master command engine.
// Turns a simple valid/ready command stream into single AHB-Lite transfers
// and returns one response per command, in command order.
//
// Pipeline: slot A holds the transfer currently in its address phase.
// Slot D holds the transfer currently in its data phase. A transfer moves
// A -> D on every edge with HREADY=1. D completes on that same edge and its
// response is presented on rsp_* for exactly the following cycle.
//
// Handshake: a command is taken on a rising HCLK edge where cmd_valid and
// cmd_ready are both 1. cmd_valid must not depend on cmd_ready. The
// response side has no backpressure: rsp_valid is a one-cycle pulse that
// the consumer must take.
//
// Illegal commands (misaligned, or size > 2) never reach the bus. They are
// taken only when both slots are empty, so their error response cannot
// overtake an earlier transfer.
module ahb_lite_master_cmd #(
  parameter logic [3:0] HPROT_VAL = 4'b0011,
  parameter int         MAX_WAIT  = 1023
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic        cmd_write,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_write,
  output logic        timeout,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  // Wait counter saturates at MAX_WAIT, so it needs MAX_WAIT+1 codes.
  localparam int            CW        = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] WAIT_MAX  = CW'(MAX_WAIT);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  // Address slot (A). a_wdata is already lane-replicated for the bus.
  logic        a_valid;
  logic [31:0] a_addr;
  logic        a_write;
  logic [2:0]  a_size;
  logic [31:0] a_wdata;

  // Data slot (D). Only the address low bits are needed to pick read lanes.
  logic        d_valid;
  logic        d_write;
  logic [1:0]  d_addr_lo;
  logic [2:0]  d_size;
  logic [31:0] hwdata_q;

  // Consecutive wait-state counter for the transfer sitting in D.
  logic [CW-1:0] wait_cnt;

  // Command decode.
  logic cmd_illegal;
  logic accept;
  logic accept_legal;
  logic accept_illegal;

  // Replicate a right-justified write value across all byte lanes so the
  // slave finds it on whichever lane the address selects.
  function automatic logic [31:0] replicate_wdata(input logic [31:0] wd,
                                                  input logic [2:0]  size);
    logic [31:0] r;
    case (size)
      3'd0:    r = {4{wd[7:0]}};
      3'd1:    r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  // Pick the active lane of HRDATA and right-justify it, zero-extended.
  function automatic logic [31:0] select_rdata(input logic [31:0] rd,
                                               input logic [1:0]  lo,
                                               input logic [2:0]  size);
    logic [31:0] r;
    r = 32'h0;
    case (size)
      3'd0: begin
        case (lo)
          2'd0:    r = {24'h0, rd[7:0]};
          2'd1:    r = {24'h0, rd[15:8]};
          2'd2:    r = {24'h0, rd[23:16]};
          default: r = {24'h0, rd[31:24]};
        endcase
      end
      3'd1:    r = lo[1] ? {16'h0, rd[31:16]} : {16'h0, rd[15:0]};
      default: r = rd;
    endcase
    return r;
  endfunction

  // Classify the offered command and decide whether it can be taken now.
  always_comb begin
    cmd_illegal = 1'b0;
    case (cmd_size)
      3'd0:    cmd_illegal = 1'b0;
      3'd1:    cmd_illegal = cmd_addr[0];
      3'd2:    cmd_illegal = (cmd_addr[1:0] != 2'b00);
      default: cmd_illegal = 1'b1;
    endcase

    if (HRESET) begin
      cmd_ready = 1'b0;
    end else if (cmd_illegal) begin
      cmd_ready = !a_valid && !d_valid;
    end else begin
      cmd_ready = !a_valid || HREADY;
    end

    accept         = cmd_valid && cmd_ready;
    accept_legal   = accept && !cmd_illegal;
    accept_illegal = accept && cmd_illegal;
  end

  // Address slot: hold while a wait state stalls it, otherwise reload or go idle.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      a_valid <= 1'b0;
      a_addr  <= 32'h0;
      a_write <= 1'b0;
      a_size  <= 3'd0;
      a_wdata <= 32'h0;
    end else if (HREADY || !a_valid) begin
      if (accept_legal) begin
        a_valid <= 1'b1;
        a_addr  <= cmd_addr;
        a_write <= cmd_write;
        a_size  <= cmd_size;
        a_wdata <= replicate_wdata(cmd_wdata, cmd_size);
      end else begin
        a_valid <= 1'b0;
        a_addr  <= 32'h0;
        a_write <= 1'b0;
        a_size  <= 3'd0;
        a_wdata <= 32'h0;
      end
    end
  end

  // Data slot: takes over the address slot on every edge the slave is ready.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      d_valid   <= 1'b0;
      d_write   <= 1'b0;
      d_addr_lo <= 2'b00;
      d_size    <= 3'd0;
      hwdata_q  <= 32'h0;
    end else if (HREADY) begin
      d_valid   <= a_valid;
      d_write   <= a_valid && a_write;
      d_addr_lo <= a_addr[1:0];
      d_size    <= a_size;
      hwdata_q  <= (a_valid && a_write) ? a_wdata : 32'h0;
    end
  end

  // Response register: one-cycle pulse for an illegal command or a D completion.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= 32'h0;
    end else if (accept_illegal) begin
      // Both slots are empty here, so no bus completion can collide.
      rsp_valid <= 1'b1;
      rsp_err   <= 1'b1;
      rsp_write <= cmd_write;
      rsp_rdata <= 32'h0;
    end else if (HREADY && d_valid) begin
      rsp_valid <= 1'b1;
      rsp_err   <= HRESP;
      rsp_write <= d_write;
      rsp_rdata <= d_write ? 32'h0 : select_rdata(HRDATA, d_addr_lo, d_size);
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= 32'h0;
    end
  end

  // Wait-state watchdog: flag (sticky) once a data phase stalls MAX_WAIT cycles.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else if (d_valid && !HREADY) begin
      if (wait_cnt != WAIT_MAX) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (wait_cnt == WAIT_LAST) begin
        timeout <= 1'b1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end

  // Bus outputs come straight from the slot registers; only singles are issued.
  assign HTRANS    = a_valid ? TRANS_NONSEQ : TRANS_IDLE;
  assign HADDR     = a_addr;
  assign HWRITE    = a_write;
  assign HSIZE     = a_size;
  assign HWDATA    = hwdata_q;
  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahb_lite_master_cmd.sv
// Directed bench for ahb_lite_master_cmd with a small AHB-Lite slave memory.
// Expected responses and write-data values are queued as commands are driven
// and compared when the DUT produces them.
module tb_ahb_lite_master_cmd;

  localparam int MAX_WAIT = 6;

  logic        HCLK;
  logic        HRESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [2:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_write;
  logic        timeout;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        hready;
  logic        hresp;

  ahb_lite_master_cmd #(
    .HPROT_VAL(4'b0011),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_addr (cmd_addr),
    .cmd_write(cmd_write),
    .cmd_size (cmd_size),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .rsp_write(rsp_write),
    .timeout  (timeout),
    .HADDR    (HADDR),
    .HTRANS   (HTRANS),
    .HWRITE   (HWRITE),
    .HSIZE    (HSIZE),
    .HBURST   (HBURST),
    .HPROT    (HPROT),
    .HMASTLOCK(HMASTLOCK),
    .HWDATA   (HWDATA),
    .HRDATA   (HRDATA),
    .HREADY   (hready),
    .HRESP    (hresp)
  );

  // ---------------- clock / reset ----------------
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          vectors     = 0;
  int          miscompares = 0;
  logic [33:0] exp_q[$];   // {err, write, rdata}
  logic [31:0] wexp_q[$];  // expected HWDATA per write data phase
  logic [33:0] rsp_e;
  logic [31:0] wd_e;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- slave memory model ----------------
  logic [31:0] mem [0:15];
  logic        dp_valid;
  logic        dp_write;
  logic [31:0] dp_addr;
  logic [2:0]  dp_size;

  function automatic logic [31:0] merge_lane(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [1:0] lo, input logic [2:0] sz);
    logic [31:0] r;
    r = old;
    case (sz)
      3'd0:    r[lo*8 +: 8] = wd[lo*8 +: 8];
      3'd1:    r[lo[1]*16 +: 16] = wd[lo[1]*16 +: 16];
      default: r = wd;
    endcase
    return r;
  endfunction

  assign HRDATA = (dp_valid && !dp_write) ? mem[dp_addr[5:2]] : 32'h0;

  always @(posedge HCLK) begin
    if (HRESET) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= 32'h0;
      dp_size  <= 3'd0;
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
    end else if (hready) begin
      if (dp_valid && dp_write && !hresp)
        mem[dp_addr[5:2]] <= merge_lane(mem[dp_addr[5:2]], HWDATA, dp_addr[1:0], dp_size);
      dp_valid <= (HTRANS == 2'b10);
      dp_write <= HWRITE;
      dp_addr  <= HADDR;
      dp_size  <= HSIZE;
    end
  end

  // Compare responses and completing write data away from the clock edge.
  always @(negedge HCLK) begin
    if (!HRESET && rsp_valid) begin
      check("rsp_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        rsp_e = exp_q.pop_front();
        check("rsp", {30'b0, rsp_err, rsp_write, rsp_rdata}, {30'b0, rsp_e});
      end
    end
    if (!HRESET && dp_valid && dp_write && hready) begin
      check("hwdata_expected", 64'(wexp_q.size() > 0), 64'd1);
      if (wexp_q.size() > 0) begin
        wd_e = wexp_q.pop_front();
        check("hwdata", 64'(HWDATA), 64'(wd_e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  task automatic cmd_idle();
    cmd_valid = 1'b0;
    cmd_addr  = 32'h0;
    cmd_write = 1'b0;
    cmd_size  = 3'd0;
    cmd_wdata = 32'h0;
  endtask

  // Offer a command and return #1 after the edge that accepted it.
  task automatic drive(input logic [31:0] addr, input logic wr,
                       input logic [2:0] size, input logic [31:0] wd);
    logic rdy;
    int   n;
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_write = wr;
    cmd_size  = size;
    cmd_wdata = wd;
    rdy = 1'b0;
    n   = 0;
    while (!rdy && n < 50) begin
      @(negedge HCLK);
      rdy = cmd_ready;
      @(posedge HCLK);
      #1;
      n++;
    end
    check("cmd_accept", 64'(rdy), 64'd1);
  endtask

  task automatic expect_rsp(input logic err, input logic wr, input logic [31:0] rd);
    exp_q.push_back({err, wr, rd});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    HRESET = 1'b1;
    hready = 1'b1;
    hresp  = 1'b0;
    cmd_valid = 1'b1;
    cmd_addr  = 32'h8;
    cmd_write = 1'b1;
    cmd_size  = 3'd2;
    cmd_wdata = 32'h12345678;
    tick(3);

    // Reset state
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_bus", {HADDR, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK}, 64'd0);
    check("rst_hprot", 64'(HPROT), 64'h3);
    check("rst_hwdata", 64'(HWDATA), 64'd0);
    check("rst_rsp", {rsp_valid, rsp_err, rsp_write, rsp_rdata, timeout}, 64'd0);
    cmd_idle();
    HRESET = 1'b0;
    tick(1);

    // Word write then read back-to-back
    expect_rsp(1'b0, 1'b1, 32'h0);
    wexp_q.push_back(32'h76543210);
    drive(32'h8, 1'b1, 3'd2, 32'h76543210);
    check("t1_wr_addr", {HTRANS, HWRITE, HSIZE, HADDR}, {2'b10, 1'b1, 3'd2, 32'h8});
    expect_rsp(1'b0, 1'b0, 32'h76543210);
    drive(32'h8, 1'b0, 3'd2, 32'h0);
    check("t1_rd_addr", {HTRANS, HWRITE, HSIZE, HADDR}, {2'b10, 1'b0, 3'd2, 32'h8});
    cmd_idle();
    tick(1);
    check("t1_idle", 64'(HTRANS), 64'd0);
    tick(3);

    // Halfword writes, word read
    expect_rsp(1'b0, 1'b1, 32'h0);
    wexp_q.push_back(32'hAAAAAAAA);
    drive(32'h4, 1'b1, 3'd1, 32'h0000AAAA);
    expect_rsp(1'b0, 1'b1, 32'h0);
    wexp_q.push_back(32'hBBBBBBBB);
    drive(32'h6, 1'b1, 3'd1, 32'h0000BBBB);
    expect_rsp(1'b0, 1'b0, 32'hBBBBAAAA);
    drive(32'h4, 1'b0, 3'd2, 32'h0);
    cmd_idle();
    tick(4);

    // Byte writes, byte read
    expect_rsp(1'b0, 1'b1, 32'h0);
    wexp_q.push_back(32'hCCCCCCCC);
    drive(32'h4, 1'b1, 3'd0, 32'h000000CC);
    expect_rsp(1'b0, 1'b1, 32'h0);
    wexp_q.push_back(32'hDDDDDDDD);
    drive(32'h6, 1'b1, 3'd0, 32'h000000DD);
    expect_rsp(1'b0, 1'b0, 32'h000000DD);
    drive(32'h6, 1'b0, 3'd0, 32'h0);
    cmd_idle();
    tick(4);

    // Three wait states on a read; next command held in address phase
    expect_rsp(1'b0, 1'b0, 32'h76543210);
    drive(32'h8, 1'b0, 3'd2, 32'h0);
    expect_rsp(1'b0, 1'b1, 32'h0);
    wexp_q.push_back(32'h11223344);
    drive(32'hC, 1'b1, 3'd2, 32'h11223344);
    cmd_idle();
    hready = 1'b0;
    repeat (3) begin
      @(negedge HCLK);
      check("t4_hold", {rsp_valid, HTRANS, HWRITE, HADDR}, {1'b0, 2'b10, 1'b1, 32'hC});
      @(posedge HCLK);
      #1;
    end
    hready = 1'b1;
    tick(4);
    check("t4_no_timeout", 64'(timeout), 64'd0);

    // Wait-state watchdog: MAX_WAIT-1 waits do not trip it, MAX_WAIT do
    expect_rsp(1'b0, 1'b0, 32'h11223344);
    drive(32'hC, 1'b0, 3'd2, 32'h0);
    cmd_idle();
    tick(1);
    hready = 1'b0;
    tick(MAX_WAIT - 1);
    hready = 1'b1;
    check("to_below", 64'(timeout), 64'd0);
    tick(2);
    expect_rsp(1'b0, 1'b0, 32'h11223344);
    drive(32'hC, 1'b0, 3'd2, 32'h0);
    cmd_idle();
    tick(1);
    hready = 1'b0;
    tick(MAX_WAIT - 1);
    check("to_one_short", 64'(timeout), 64'd0);
    tick(1);
    check("to_reached", 64'(timeout), 64'd1);
    hready = 1'b1;
    tick(3);
    check("to_sticky", 64'(timeout), 64'd1);

    // Two-cycle ERROR on a write with a read waiting in the address slot
    expect_rsp(1'b1, 1'b1, 32'h0);
    wexp_q.push_back(32'h5555AAAA);
    drive(32'h10, 1'b1, 3'd2, 32'h5555AAAA);
    expect_rsp(1'b0, 1'b0, 32'h76543210);
    drive(32'h8, 1'b0, 3'd2, 32'h0);
    cmd_idle();
    hready = 1'b0;
    hresp  = 1'b1;
    tick(1);
    check("err_a_held", {rsp_valid, HTRANS, HWRITE, HADDR}, {1'b0, 2'b10, 1'b0, 32'h8});
    hready = 1'b1;
    tick(1);
    hresp = 1'b0;
    tick(2);

    // Misaligned word read: no bus transfer, error response
    expect_rsp(1'b1, 1'b0, 32'h0);
    drive(32'h2, 1'b0, 3'd2, 32'h0);
    check("mis_no_nonseq0", 64'(HTRANS), 64'd0);
    cmd_idle();
    tick(1);
    check("mis_no_nonseq1", 64'(HTRANS), 64'd0);
    tick(1);

    // Misaligned halfword waits behind an outstanding read
    expect_rsp(1'b0, 1'b0, 32'h76543210);
    drive(32'h8, 1'b0, 3'd2, 32'h0);
    cmd_valid = 1'b1;
    cmd_addr  = 32'h5;
    cmd_write = 1'b0;
    cmd_size  = 3'd1;
    @(negedge HCLK);
    check("mis_blocked", 64'(cmd_ready), 64'd0);
    expect_rsp(1'b1, 1'b0, 32'h0);
    drive(32'h5, 1'b0, 3'd1, 32'h0);
    cmd_idle();
    tick(2);

    // Size 3 is illegal
    expect_rsp(1'b1, 1'b0, 32'h0);
    drive(32'h0, 1'b0, 3'd3, 32'h0);
    check("sz3_no_nonseq", 64'(HTRANS), 64'd0);
    cmd_idle();
    tick(3);

    // Reset during a wait state with two transfers outstanding
    drive(32'h8, 1'b0, 3'd2, 32'h0);
    drive(32'hC, 1'b0, 3'd2, 32'h0);
    cmd_idle();
    hready = 1'b0;
    tick(1);
    HRESET    = 1'b1;
    cmd_valid = 1'b1;
    check("rst_mid_ready", 64'(cmd_ready), 64'd0);
    tick(1);
    check("rst_mid_bus", {HTRANS, HWRITE, HSIZE, HADDR}, 64'd0);
    check("rst_mid_rsp", {rsp_valid, rsp_err, timeout, HWDATA}, 64'd0);
    tick(1);
    check("rst_mid_ready2", 64'(cmd_ready), 64'd0);
    HRESET = 1'b0;
    hready = 1'b1;
    cmd_idle();
    tick(1);
    check("rst_release_ready", 64'(cmd_ready), 64'd1);

    // Traffic resumes after reset
    expect_rsp(1'b0, 1'b1, 32'h0);
    wexp_q.push_back(32'hCAFEF00D);
    drive(32'h14, 1'b1, 3'd2, 32'hCAFEF00D);
    expect_rsp(1'b0, 1'b0, 32'hCAFEF00D);
    drive(32'h14, 1'b0, 3'd2, 32'h0);
    cmd_idle();
    tick(5);

    check("rsp_queue_drained", 64'(exp_q.size()), 64'd0);
    check("wdata_queue_drained", 64'(wexp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
